tuning_dial: RTL and testbench



---
 rtl/tuning_pkg.sv | 16 +
 rtl/tuning_dial_debounce.sv | 34 +++
 rtl/tuning_dial.sv | 98 +++++++++
 tb/tb_tuning_dial.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/tuning_pkg.sv
// tuning_pkg: widths, NCO conversion constants and FSM encoding shared by the tuning dial.
package tuning_pkg;
  localparam int PHASE_W = 27;
  localparam int FQ_W = 23;
  localparam longint unsigned PHASE_MULT = 140_737_488;
  localparam int PHASE_SHIFT = 24;
  localparam int SAMPLE_CLK_FQ = 16_000_000;
  localparam int PROD_W = PHASE_SHIFT + PHASE_W;
  typedef enum logic [1:0] {S_IDLE, S_STEP, S_MUL, S_OUT} state_t;
  // Round-to-nearest of fq * 2^27 / 16 MHz; the product never exceeds 51 bits for fq < 2^23
  function automatic logic [PHASE_W-1:0] fq_to_phase(input logic [FQ_W-1:0] fq);
    logic [PROD_W-1:0] p;
    p = PROD_W'(fq) * PROD_W'(PHASE_MULT) + (PROD_W'(1) << (PHASE_SHIFT - 1));
    return p[PHASE_SHIFT +: PHASE_W];
  endfunction
endpackage

// File: rtl/tuning_dial_debounce.sv
// debounce: 2-FF synchronizer followed by a stability counter that accepts a level
// only after it has differed from the output for CYCLES consecutive cycles.
module debounce #(
  parameter int unsigned CYCLES = 128_000
) (
  input  logic aclk,
  input  logic reset,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(CYCLES + 1);
  logic s1_q, s2_q, dout_q, dout_d;
  logic [CW-1:0] cnt_q, cnt_d, inc;
  always_ff @(posedge aclk) begin
    s1_q <= din;
    s2_q <= s1_q;
  end
  always_comb begin
    inc = cnt_q + 1'b1;
    cnt_d = s2_q != dout_q && inc != CW'(CYCLES) ? inc : '0;
    dout_d = s2_q != dout_q && inc == CW'(CYCLES) ? s2_q : dout_q;
  end
  // Reset adopts the current synchronized level so release never looks like an edge
  always_ff @(posedge aclk) begin
    if (reset) begin
      dout_q <= s2_q;
      cnt_q <= '0;
    end else begin
      dout_q <= dout_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout = dout_q;
endmodule

// File: rtl/tuning_dial.sv
// tuning_dial: decodes debounced dial detents into band-limited frequency steps and
// publishes the matching NCO phase increment with a one-cycle valid pulse.
module tuning_dial import tuning_pkg::*; #(
  parameter int unsigned FQ_MIN = 500_000,
  parameter int unsigned FQ_MAX = 1_800_000,
  parameter int unsigned FQ_RESET = 1_000_000,
  parameter int unsigned STEP_FINE = 1_000,
  parameter int unsigned STEP_COARSE = 9_000,
  parameter int unsigned DEBOUNCE_CYCLES = 128_000
) (
  input  logic aclk,
  input  logic reset,
  input  logic fq_ck,
  input  logic fq_dt,
  input  logic step_sel,
  output logic [FQ_W-1:0] fq_hz,
  output logic [PHASE_W-1:0] phase_inc,
  output logic phase_inc_valid
);
  state_t state_q, state_d;
  logic ck_db, dt_db, ck_prev_q, detent, idle_go, direct, capture;
  logic boot_q, pend_q, pend_d, pend_up_q, pend_up_d, pend_crs_q, pend_crs_d;
  logic cur_up_q, cur_up_d, cur_crs_q, cur_crs_d, valid_q, valid_d;
  logic [FQ_W-1:0] fq_q, fq_d, step, fq_step;
  logic [FQ_W:0] up_sum;
  logic [PHASE_W-1:0] phase_q, phase_d;
  debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_ck (
    .aclk(aclk),
    .reset(reset),
    .din(fq_ck),
    .dout(ck_db)
  );
  debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_dt (
    .aclk(aclk),
    .reset(reset),
    .din(fq_dt),
    .dout(dt_db)
  );
  always_ff @(posedge aclk)
    state_q <= reset ? S_IDLE : state_d;
  // boot_q forces one conversion of FQ_RESET right after reset
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: state_d = boot_q ? S_MUL : (pend_q || detent) ? S_STEP : S_IDLE;
      S_STEP: state_d = fq_step != fq_q ? S_MUL : S_IDLE;
      S_MUL: state_d = S_OUT;
      default: state_d = S_IDLE;
    endcase
  end
  // A detent is taken directly only in a free IDLE; otherwise it fills the empty pending slot or is dropped
  always_comb begin
    detent = ck_prev_q & ~ck_db;
    idle_go = state_q == S_IDLE && !boot_q;
    direct = idle_go && !pend_q && detent;
    capture = !pend_q && detent && !direct;
    step = cur_crs_q ? FQ_W'(STEP_COARSE) : FQ_W'(STEP_FINE);
    up_sum = {1'b0, fq_q} + {1'b0, step};
    fq_step = cur_up_q ? (up_sum > (FQ_W + 1)'(FQ_MAX) ? FQ_W'(FQ_MAX) : up_sum[FQ_W-1:0])
                       : ({1'b0, fq_q} < (FQ_W + 1)'(FQ_MIN) + {1'b0, step} ? FQ_W'(FQ_MIN) : fq_q - step);
    pend_d = pend_q ? !idle_go : capture;
    pend_up_d = capture ? dt_db : pend_up_q;
    pend_crs_d = capture ? step_sel : pend_crs_q;
    cur_up_d = direct ? dt_db : (idle_go && pend_q) ? pend_up_q : cur_up_q;
    cur_crs_d = direct ? step_sel : (idle_go && pend_q) ? pend_crs_q : cur_crs_q;
    fq_d = state_q == S_STEP ? fq_step : fq_q;
    phase_d = state_q == S_MUL ? fq_to_phase(fq_q) : phase_q;
    valid_d = state_q == S_MUL;
  end
  always_ff @(posedge aclk) begin
    if (reset) begin
      boot_q <= 1'b1;
      ck_prev_q <= 1'b0;
      pend_q <= 1'b0;
      pend_up_q <= 1'b0;
      pend_crs_q <= 1'b0;
      cur_up_q <= 1'b0;
      cur_crs_q <= 1'b0;
      fq_q <= FQ_W'(FQ_RESET);
      phase_q <= '0;
      valid_q <= 1'b0;
    end else begin
      boot_q <= 1'b0;
      ck_prev_q <= ck_db;
      pend_q <= pend_d;
      pend_up_q <= pend_up_d;
      pend_crs_q <= pend_crs_d;
      cur_up_q <= cur_up_d;
      cur_crs_q <= cur_crs_d;
      fq_q <= fq_d;
      phase_q <= phase_d;
      valid_q <= valid_d;
    end
  end
  assign fq_hz = fq_q;
  assign phase_inc = phase_q;
  assign phase_inc_valid = valid_q;
endmodule

// File: tb/tb_tuning_dial.sv
// tb_tuning_dial: table-driven scoreboard checks on a short-debounce build, plus
// saturation and pending-detent sequences on a single-cycle-debounce build.
module tb_tuning_dial;
  localparam int DA = 16;
  typedef struct {int fq; int ph;} exp_t;
  typedef struct {bit up; bit crs; int fq; int ph;} vec_t;
  logic aclk = 1'b0;
  logic reset_a, ck_a, dt_a, sel_a, valid_a;
  logic reset_b, ck_b, dt_b, sel_b, valid_b;
  logic [22:0] fq_a, fq_b;
  logic [26:0] ph_a, ph_b;
  int checks = 0;
  int errors = 0;
  int cnt_b = 0;
  exp_t sb[$];
  vec_t vt[6];
  always #5 aclk = ~aclk;
  tuning_dial #(.DEBOUNCE_CYCLES(DA)) dut_a (
    .aclk(aclk), .reset(reset_a), .fq_ck(ck_a), .fq_dt(dt_a), .step_sel(sel_a),
    .fq_hz(fq_a), .phase_inc(ph_a), .phase_inc_valid(valid_a)
  );
  tuning_dial #(.DEBOUNCE_CYCLES(1)) dut_b (
    .aclk(aclk), .reset(reset_b), .fq_ck(ck_b), .fq_dt(dt_b), .step_sel(sel_b),
    .fq_hz(fq_b), .phase_inc(ph_b), .phase_inc_valid(valid_b)
  );
  function automatic int phase_of(int fq);
    longint p;
    p = longint'(fq) * 64'd140737488 + 64'd8388608;
    return int'(p >> 24);
  endfunction
  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask
  task automatic detent_a(bit up, bit crs);
    dt_a = up;
    sel_a = crs;
    tick(DA + 6);
    ck_a = 1'b0;
    tick(DA + 6);
    ck_a = 1'b1;
    tick(DA + 6);
  endtask
  task automatic detent_b(bit up, bit crs);
    dt_b = up;
    sel_b = crs;
    tick(4);
    ck_b = 1'b0;
    tick(4);
    ck_b = 1'b1;
    tick(4);
  endtask
  task automatic release_a();
    sb.push_back('{1000000, 8388608});
    @(posedge aclk);
    #1 reset_a = 1'b0;
    tick(1);
    chk("boot_valid_early", valid_a, 0);
    tick(1);
    chk("boot_valid", valid_a, 1);
    chk("boot_ph", ph_a, 8388608);
    chk("boot_fq", fq_a, 1000000);
    tick(1);
    chk("boot_valid_width", valid_a, 0);
  endtask
  always @(negedge aclk) begin
    exp_t e;
    if (valid_a) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_fq", fq_a, e.fq);
        chk("sb_ph", ph_a, e.ph);
      end
    end
  end
  always @(negedge aclk) if (valid_b) cnt_b++;
  initial begin
    int base;
    bit seen;
    vt[0] = '{1'b1, 1'b0, 1001000, 8396997};
    vt[1] = '{1'b0, 1'b0, 1000000, 8388608};
    vt[2] = '{1'b1, 1'b1, 1009000, 8464105};
    vt[3] = '{1'b0, 1'b1, 1000000, 8388608};
    vt[4] = '{1'b0, 1'b1, 991000, phase_of(991000)};
    vt[5] = '{1'b1, 1'b0, 992000, phase_of(992000)};
    reset_a = 1'b1;
    reset_b = 1'b1;
    ck_a = 1'b1;
    dt_a = 1'b1;
    sel_a = 1'b0;
    ck_b = 1'b1;
    dt_b = 1'b1;
    sel_b = 1'b0;
    tick(6);
    chk("rst_fq", fq_a, 1000000);
    chk("rst_ph", ph_a, 0);
    chk("rst_valid", valid_a, 0);
    reset_b = 1'b0;
    release_a();
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{vt[i].fq, vt[i].ph});
      detent_a(vt[i].up, vt[i].crs);
      chk($sformatf("vec%0d_fq", i), fq_a, vt[i].fq);
      chk($sformatf("vec%0d_drained", i), sb.size(), 0);
    end
    ck_a = 1'b0;
    tick(DA - 1);
    ck_a = 1'b1;
    tick(3 * DA);
    chk("glitch_short_fq", fq_a, 992000);
    sb.push_back('{993000, phase_of(993000)});
    ck_a = 1'b0;
    tick(DA);
    ck_a = 1'b1;
    tick(3 * DA);
    chk("glitch_full_fq", fq_a, 993000);
    chk("glitch_full_drained", sb.size(), 0);
    dt_a = 1'b1;
    sel_a = 1'b0;
    ck_a = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4 * DA && !seen; i++) begin
      tick(1);
      seen = fq_a != 23'd993000;
    end
    chk("midop_step_seen", seen, 1);
    reset_a = 1'b1;
    tick(1);
    chk("midop_valid", valid_a, 0);
    chk("midop_fq", fq_a, 1000000);
    chk("midop_ph", ph_a, 0);
    ck_a = 1'b1;
    tick(4);
    chk("midop_sb", sb.size(), 0);
    release_a();
    base = cnt_b;
    repeat (2000) detent_b(1'b1, 1'b0);
    chk("sat_hi_fq", fq_b, 1800000);
    chk("sat_hi_ph", ph_b, 15099494);
    chk("sat_hi_pulses", cnt_b - base, 800);
    base = cnt_b;
    repeat (5) detent_b(1'b1, 1'b0);
    chk("sat_hi_quiet", cnt_b - base, 0);
    base = cnt_b;
    repeat (200) detent_b(1'b0, 1'b1);
    chk("sat_lo_fq", fq_b, 500000);
    chk("sat_lo_ph", ph_b, 4194304);
    chk("sat_lo_pulses", cnt_b - base, 145);
    dt_b = 1'b1;
    sel_b = 1'b0;
    tick(4);
    base = cnt_b;
    for (int i = 0; i < 3; i++) begin
      ck_b = 1'b0;
      tick(1);
      ck_b = 1'b1;
      tick(1);
    end
    tick(20);
    chk("pend_pulses", cnt_b - base, 2);
    chk("pend_fq", fq_b, 502000);
    chk("pend_ph", ph_b, phase_of(502000));
    chk("sb_final", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
